pipeline_stall_controller: RTL

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Combines the hazard detector's

---
 rtl/pipeline_stall_controller.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard stalls, branch flushes, memory waits.
// Define STALL_PERF_CNT_EN to build the saturating performance counters; otherwise they read 0.
module pipeline_stall_controller #(
    parameter int unsigned MEM_TIMEOUT   = 16,
    parameter int unsigned MAX_HAZ_STALL = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard_stall,
    input  logic             ID_BranchTaken,
    input  logic             MEM_req,
    input  logic             MEM_ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Flush,
    output logic             mem_timeout_err,
    output logic             haz_overrun_err,
    output logic [CNT_W-1:0] haz_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned HAZ_W  = $clog2(MAX_HAZ_STALL + 2);
    // The first frozen cycle is spent in RUN, so MEM_WAIT sees MEM_TIMEOUT-1 of them.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 2);
    localparam logic [HAZ_W-1:0]  HAZ_MAX   = HAZ_W'(MAX_HAZ_STALL);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [HAZ_W-1:0]  haz_run;
    logic              freeze;
    logic              haz_active;

    assign freeze     = MEM_req & ~MEM_ready;
    assign haz_active = hazard_stall & ~freeze;

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Write = 1'b1;
        MEM_WB_Flush = 1'b0;
        if (!reset) begin
            if (freeze) begin
                PC_Write     = 1'b0;
                IF_ID_Write  = 1'b0;
                EX_MEM_Write = 1'b0;
                MEM_WB_Flush = 1'b1;
            end else if (hazard_stall) begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Flush = 1'b1;
            end else if (ID_BranchTaken) begin
                IF_ID_Flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= RUN;
            wait_cnt        <= '0;
            haz_run         <= '0;
            mem_timeout_err <= 1'b0;
            haz_overrun_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    wait_cnt <= '0;
                    if (freeze)
                        state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (!freeze) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_timeout_err <= 1'b1;
                        state           <= RUN;
                        wait_cnt        <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase

            // Run length holds across a freeze; the stall itself is always honoured.
            if (!hazard_stall) begin
                haz_run <= '0;
            end else if (!freeze) begin
                if (haz_run == HAZ_MAX)
                    haz_overrun_err <= 1'b1;
                else
                    haz_run <= haz_run + 1'b1;
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] haz_q, mem_q, flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            haz_q   <= '0;
            mem_q   <= '0;
            flush_q <= '0;
        end else begin
            if (haz_active && haz_q != '1)
                haz_q <= haz_q + 1'b1;
            if (freeze && mem_q != '1)
                mem_q <= mem_q + 1'b1;
            if (IF_ID_Flush && flush_q != '1)
                flush_q <= flush_q + 1'b1;
        end
    end

    assign haz_stall_cnt = haz_q;
    assign mem_stall_cnt = mem_q;
    assign flush_cnt     = flush_q;
`else
    assign haz_stall_cnt = '0;
    assign mem_stall_cnt = '0;
    assign flush_cnt     = '0;
`endif

endmodule
